// File: rtl/upsample_writer.sv
// Nearest-neighbour upsampler: reads a di x dr x dc map through a shared RAM port and
// writes each byte as a step x step block. Optional `UPSAMPLE_ZERO_FILL_EN gives sparse unpooling output.
module upsample_writer #(
    parameter int memaddrbit = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2:0]            step,
    input  logic [memaddrbit-1:0] dr,
    input  logic [memaddrbit-1:0] dc,
    input  logic [memaddrbit-1:0] di,
    input  logic [memaddrbit-1:0] inaddr,
    input  logic [memaddrbit-1:0] outaddr,
    input  logic                  checkram,
    input  logic [7:0]            data_in,
    output logic [memaddrbit-1:0] memaddr,
    output logic [7:0]            data_out,
    output logic                  wea,
    output logic [memaddrbit-1:0] ir,
    output logic [memaddrbit-1:0] ic,
    output logic [memaddrbit-1:0] ii,
    output logic [2:0]            state,
    output logic                  picture_finish
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        NEXT  = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [1:0]              count_rd_reg;
    logic [2:0]              jr_reg, jc_reg;
    logic [7:0]              hold_reg;
    logic [memaddrbit-1:0]   memaddr_reg, ir_reg, ic_reg, ii_reg;
    logic [7:0]              data_out_reg;
    logic                    wea_reg, finish_reg;

    logic [2:0]              s_val;
    logic [memaddrbit-1:0]   s_ext, out_rows, out_cols, rd_addr, wr_addr;
    logic [7:0]              wr_data;
    logic                    last_jc, last_jr;

    always_comb begin
        s_val    = (step == 3'd0) ? 3'd1 : step;
        s_ext    = memaddrbit'(s_val);
        out_rows = dr * s_ext;
        out_cols = dc * s_ext;
        rd_addr  = inaddr + ii_reg * dr * dc + ir_reg * dc + ic_reg;
        wr_addr  = outaddr + ii_reg * out_rows * out_cols
                 + (ir_reg * s_ext + memaddrbit'(jr_reg)) * out_cols
                 + ic_reg * s_ext + memaddrbit'(jc_reg);
        last_jc  = (jc_reg == s_val - 3'd1);
        last_jr  = (jr_reg == s_val - 3'd1);
`ifdef UPSAMPLE_ZERO_FILL_EN
        // Sparse map: only the top-left corner of each block carries the source value
        wr_data  = (jr_reg == 3'd0 && jc_reg == 3'd0) ? hold_reg : 8'd0;
`else
        wr_data  = hold_reg;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_rd_reg <= 2'd0;
            jr_reg       <= 3'd0;
            jc_reg       <= 3'd0;
            hold_reg     <= 8'd0;
            memaddr_reg  <= '0;
            data_out_reg <= 8'd0;
            wea_reg      <= 1'b0;
            ir_reg       <= '0;
            ic_reg       <= '0;
            ii_reg       <= '0;
            finish_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    memaddr_reg <= '0;
                    wea_reg     <= 1'b0;
                    if (enable) begin
                        state_reg    <= READ;
                        finish_reg   <= 1'b0;
                        ir_reg       <= '0;
                        ic_reg       <= '0;
                        ii_reg       <= '0;
                        count_rd_reg <= 2'd0;
                    end
                end
                READ: begin
                    wea_reg <= 1'b0;
                    if (count_rd_reg == 2'd0)
                        memaddr_reg <= rd_addr;
                    // Read data lands two cycles after the address; sample one cycle later
                    if (count_rd_reg == 2'd3) begin
                        hold_reg     <= data_in;
                        count_rd_reg <= 2'd0;
                        jr_reg       <= 3'd0;
                        jc_reg       <= 3'd0;
                        state_reg    <= WRITE;
                    end else begin
                        count_rd_reg <= count_rd_reg + 2'd1;
                    end
                end
                WRITE: begin
                    memaddr_reg  <= wr_addr;
                    data_out_reg <= wr_data;
                    wea_reg      <= 1'b1;
                    if (last_jc) begin
                        jc_reg <= 3'd0;
                        if (last_jr) begin
                            jr_reg    <= 3'd0;
                            state_reg <= NEXT;
                        end else begin
                            jr_reg <= jr_reg + 3'd1;
                        end
                    end else begin
                        jc_reg <= jc_reg + 3'd1;
                    end
                end
                NEXT: begin
                    memaddr_reg <= '0;
                    wea_reg     <= 1'b0;
                    state_reg   <= READ;
                    if (ic_reg == dc - 1'b1) begin
                        ic_reg <= '0;
                        if (ir_reg == dr - 1'b1) begin
                            ir_reg <= '0;
                            if (ii_reg == di - 1'b1) begin
                                ii_reg     <= '0;
                                finish_reg <= 1'b1;
                                state_reg  <= checkram ? CHECK : IDLE;
                            end else begin
                                ii_reg <= ii_reg + 1'b1;
                            end
                        end else begin
                            ir_reg <= ir_reg + 1'b1;
                        end
                    end else begin
                        ic_reg <= ic_reg + 1'b1;
                    end
                end
                CHECK: begin
                    memaddr_reg <= '0;
                    wea_reg     <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    memaddr_reg <= '0;
                    wea_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign memaddr        = memaddr_reg;
    assign data_out       = data_out_reg;
    assign wea            = wea_reg;
    assign ir             = ir_reg;
    assign ic             = ic_reg;
    assign ii             = ii_reg;
    assign state          = state_reg;
    assign picture_finish = finish_reg;

endmodule

// File: tb/tb_upsample_writer.sv
// Scoreboard bench for upsample_writer: a behavioural RAM model, expected writes queued
// from output-map coordinates, and a monitor comparing every write strobe.
module tb_upsample_writer;
    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   step = 3'd1;
    logic [W-1:0] dr = 1, dc = 1, di = 1, inaddr = '0, outaddr = '0;
    logic         checkram = 1'b0;
    logic [7:0]   data_in;
    logic [W-1:0] memaddr;
    logic [7:0]   data_out;
    logic         wea;
    logic [W-1:0] ir, ic, ii;
    logic [2:0]   state;
    logic         picture_finish;

    upsample_writer #(.memaddrbit(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .step(step),
        .dr(dr), .dc(dc), .di(di), .inaddr(inaddr), .outaddr(outaddr),
        .checkram(checkram), .data_in(data_in), .memaddr(memaddr),
        .data_out(data_out), .wea(wea), .ir(ir), .ic(ic), .ii(ii),
        .state(state), .picture_finish(picture_finish)
    );

    always #5 clk = ~clk;

    // RAM model: host load port has priority, reads have two cycles of latency
    bit   [7:0]   mem [0:(1<<W)-1];
    logic         host_we = 1'b0;
    logic [W-1:0] host_addr = '0;
    logic [7:0]   host_data = 8'd0;
    logic [7:0]   rd1 = 8'd0;
    initial data_in = 8'd0;
    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_data;
        else if (wea) mem[memaddr] <= data_out;
        rd1     <= mem[memaddr];
        data_in <= rd1;
    end

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    wr_t chk_q[$];
    int  src_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cur_n, cur_s;
    bit  cur_ck;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (wea) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", memaddr, data_out);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (int'(memaddr) != e.addr || int'(data_out) != e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             memaddr, data_out, e.addr, e.data);
                end else begin
                    $display("write addr 0x%0h data 0x%0h", memaddr, data_out);
                end
            end
        end
    end

    task automatic start_job(input int ddi, input int ddr, input int ddc, input int st,
                             input int ia, input int oa, input bit ck);
        int s, n, R, C, v, idx;
        wr_t w;
        s = (st == 0) ? 1 : st;
        n = ddi * ddr * ddc;
        if (src_q.size() != n) begin
            src_q.delete();
            for (int e = 0; e < n; e++) src_q.push_back(int'($urandom_range(0, 255)));
        end
        for (int e = 0; e < n; e++) begin
            @(negedge clk);
            host_we = 1'b1; host_addr = W'(ia + e); host_data = 8'(src_q[e]);
        end
        @(negedge clk);
        host_we = 1'b0;
        R = ddr * s; C = ddc * s;
        chk_q.delete();
        // Expected writes in source order, each block swept row-major over the enlarged map
        for (int z = 0; z < ddi; z++)
            for (int r = 0; r < ddr; r++)
                for (int c = 0; c < ddc; c++)
                    for (int jr = 0; jr < s; jr++)
                        for (int jc = 0; jc < s; jc++) begin
                            v = src_q[(z * ddr + r) * ddc + c];
`ifdef UPSAMPLE_ZERO_FILL_EN
                            if (jr != 0 || jc != 0) v = 0;
`endif
                            idx = z * R * C + (r * s + jr) * C + c * s + jc;
                            w.addr = (oa + idx) & ((1 << W) - 1);
                            w.data = v;
                            exp_q.push_back(w);
                            chk_q.push_back(w);
                        end
        di = W'(ddi); dr = W'(ddr); dc = W'(ddc); step = 3'(st);
        inaddr = W'(ia); outaddr = W'(oa); checkram = ck;
        cur_n = n; cur_s = s; cur_ck = ck;
        $display("job di=%0d dr=%0d dc=%0d step=%0d in=0x%0h out=0x%0h checkram=%0d",
                 ddi, ddr, ddc, st, ia, oa, ck);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic finish_job();
        int cycles, budget;
        cycles = 1;
        budget = 1 + cur_n * (5 + cur_s * cur_s) + 50;
        while (picture_finish !== 1'b1 && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("finish_cycles", cycles, 1 + cur_n * (5 + cur_s * cur_s));
        check("finish_state", int'(state), cur_ck ? 4 : 0);
        check("pending_writes", exp_q.size(), 0);
        foreach (chk_q[k]) check("ram_content", int'(mem[chk_q[k].addr]), chk_q[k].data);
        src_q.delete();
    endtask

    task automatic run_job(input int ddi, input int ddr, input int ddc, input int st,
                           input int ia, input int oa, input bit ck);
        start_job(ddi, ddr, ddc, st, ia, oa, ck);
        finish_job();
    endtask

    initial begin
        int map2[16];
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_wea", int'(wea), 0);
        check("reset_memaddr", int'(memaddr), 0);
        check("reset_finish", int'(picture_finish), 0);
        check("reset_idx", int'(ir) + int'(ic) + int'(ii), 0);
        @(negedge clk); rst = 1'b1;

        // Single element, 2x2 block
        src_q = '{8'h5A};
        run_job(1, 1, 1, 2, 100, 4000, 1'b0);
        check("case1_finish", int'(picture_finish), 1);

        // 2x2 source, step 2, explicit output map
        src_q = '{1, 2, 3, 4};
        run_job(1, 2, 2, 2, 200, 5000, 1'b0);
`ifdef UPSAMPLE_ZERO_FILL_EN
        map2 = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
`else
        map2 = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
`endif
        for (int k = 0; k < 16; k++) check("case2_map", int'(mem[5000 + k]), map2[k]);

        // Plain copy with step 1 and step 0
        run_job(2, 2, 2, 1, 300, 6000, 1'b0);
        run_job(2, 2, 2, 0, 320, 6100, 1'b0);

        // Output address wraps past the top of the address space
        run_job(1, 1, 1, 4, 100, 16380, 1'b0);

        // Reset during WRITE aborts immediately
        src_q = '{1, 2, 3, 4};
        start_job(1, 2, 2, 2, 200, 7000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_in_write", int'(state), 2);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_wea", int'(wea), 0);
        check("abort_state", int'(state), 0);
        check("abort_idx", int'(ir) + int'(ic) + int'(ii), 0);
        check("abort_memaddr", int'(memaddr), 0);
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", int'(wea), 0);
        src_q = '{1, 2, 3, 4};
        run_job(1, 2, 2, 2, 200, 7000, 1'b0);

        // Parking in CHECK with enable toggling
        src_q = '{8'h5A};
        run_job(1, 1, 1, 2, 100, 8000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); enable = ~enable;
            @(posedge clk); #1;
            check("check_state", int'(state), 4);
            check("check_wea", int'(wea), 0);
        end
        @(negedge clk); enable = 1'b0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Randomized jobs
        for (int t = 0; t < 8; t++)
            run_job(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 1000)),
                    int'($urandom_range(2000, 14000)), 1'b0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
